// File: rtl/time_keeper_if.sv
// time_keeper_if -- control inputs and BCD time outputs of the time keeper.
//   tick                 1 Hz one-cycle enable
//   setMode              1 = time-set mode, 0 = run mode
//   incHour / incMin     debounced increment buttons (levels)
//   curHour1..curSec0    BCD time digits hh:mm:ss
//   minTick              one-cycle pulse when an hour/minute digit changes
// Modports: master drives the controls, slave is the time keeper itself.
interface time_keeper_if;
    logic       tick;
    logic       setMode;
    logic       incHour;
    logic       incMin;
    logic [3:0] curHour1, curHour0;
    logic [3:0] curMin1, curMin0;
    logic [3:0] curSec1, curSec0;
    logic       minTick;

    modport master (
        output tick, setMode, incHour, incMin,
        input  curHour1, curHour0, curMin1, curMin0, curSec1, curSec0, minTick
    );
    modport slave (
        input  tick, setMode, incHour, incMin,
        output curHour1, curHour0, curMin1, curMin0, curSec1, curSec0, minTick
    );
endinterface

// File: rtl/time_keeper.sv
// time_keeper -- 24 h BCD clock with set mode and auto-repeat buttons.
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset (time reads 00:00:00)
//   tk      time_keeper_if.slave: tick/setMode/incHour/incMin in,
//           BCD digits and minTick out (all registered)
// time_keeper_btn -- per-button IDLE/HELD/REPEAT auto-repeat FSM; inc is a
//   combinational one-cycle increment request, only raised in set mode.

module time_keeper_btn #(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic setMode,
    output logic inc
);
    localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    // armed: this press started while in set mode and set mode has held
    // since; a press carried into set mode never increments.
    logic          armed, armedNext;
    logic          pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            armed <= armedNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        armedNext = armed && setMode;
        pulse     = 1'b0;
        case (state)
            IDLE: if (btn) begin
                stateNext = HELD;
                cntNext   = '0;
                pulse     = 1'b1;
                armedNext = setMode;
            end
            HELD: if (!btn) begin
                stateNext = IDLE;
                cntNext   = '0;
                armedNext = 1'b0;
            end else if (cnt == DLY_LAST) begin
                stateNext = REPEAT;
                cntNext   = '0;
                pulse     = 1'b1;
            end else begin
                cntNext = cnt + 1'b1;
            end
            REPEAT: if (!btn) begin
                stateNext = IDLE;
                cntNext   = '0;
                armedNext = 1'b0;
            end else if (cnt == RATE_LAST) begin
                cntNext = '0;
                pulse   = 1'b1;
            end else begin
                cntNext = cnt + 1'b1;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                armedNext = 1'b0;
            end
        endcase
    end

    assign inc = pulse && armedNext;
endmodule

module time_keeper #(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input logic          clk,
    input logic          rst_n,
    time_keeper_if.slave tk
);
    // {wrap, next value}: wraps to 00 at maxV, otherwise BCD +1.
    function automatic logic [8:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
        if (v == maxV)           return 9'h100;
        else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        else                     return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [7:0] hour, min, sec;
    logic [7:0] hourNext, minNext, secNext;
    logic       minTick;
    logic       hourInc, minInc;
    logic [8:0] secStep, minStep, hourStep;

    time_keeper_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) uHourBtn (
        .clk(clk), .rst_n(rst_n), .btn(tk.incHour), .setMode(tk.setMode), .inc(hourInc)
    );
    time_keeper_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) uMinBtn (
        .clk(clk), .rst_n(rst_n), .btn(tk.incMin), .setMode(tk.setMode), .inc(minInc)
    );

    assign secStep  = bcdInc(sec,  8'h59);
    assign minStep  = bcdInc(min,  8'h59);
    assign hourStep = bcdInc(hour, 8'h23);

    // Set mode owns the edge whenever setMode is high, so a coincident
    // tick is dropped; set-mode increments never carry across fields.
    always_comb begin
        hourNext = hour;
        minNext  = min;
        secNext  = sec;
        if (tk.setMode) begin
            secNext = 8'h00;
            if (minInc)  minNext  = minStep[7:0];
            if (hourInc) hourNext = hourStep[7:0];
        end else if (tk.tick) begin
            secNext = secStep[7:0];
            if (secStep[8]) begin
                minNext = minStep[7:0];
                if (minStep[8]) hourNext = hourStep[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour    <= 8'h00;
            min     <= 8'h00;
            sec     <= 8'h00;
            minTick <= 1'b0;
        end else begin
            hour    <= hourNext;
            min     <= minNext;
            sec     <= secNext;
            minTick <= (hourNext != hour) || (minNext != min);
        end
    end

    assign {tk.curHour1, tk.curHour0} = hour;
    assign {tk.curMin1,  tk.curMin0}  = min;
    assign {tk.curSec1,  tk.curSec0}  = sec;
    assign tk.minTick = minTick;
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter: REPEAT_DELAY, 8, clk cycles an increment button must stay held before auto-repeat starts.
REQ-002 Parameter: REPEAT_RATE, 4, clk cycles between auto-repeat increments.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tick  input  1  one-cycle 1 Hz enable, synchronous to clk.
REQ-006 setMode  input  1  level; 1 = time-set mode, 0 = run mode.
REQ-007 incHour  input  1  level, synchronous and debounced; hour-increment button.
REQ-008 incMin  input  1  level, synchronous and debounced; minute-increment button.
REQ-009 curHour1, curHour0  output  4 each  BCD hour tens/units, range 00..23.
REQ-010 curMin1, curMin0  output  4 each  BCD minute tens/units, range 00..59.
REQ-011 curSec1, curSec0  output  4 each  BCD second tens/units, range 00..59.
REQ-012 minTick  output  1  one-cycle pulse on the edge where any hour or minute digit changes.

Function
REQ-013 All outputs SHALL be registered; an input sampled at edge k SHALL affect the outputs immediately after edge k.
REQ-014 In run mode, each tick SHALL advance seconds by 1 in BCD; 59 -> 00 with carry to minutes.
REQ-015 A minute carry SHALL advance minutes 59 -> 00 with carry to hours; hours SHALL wrap 23 -> 00; the whole carry chain SHALL resolve on one edge.
REQ-016 Digits SHALL never hold a non-BCD value or an out-of-range time.
REQ-017 In set mode, tick SHALL be ignored and seconds SHALL be forced to 00 on the first set-mode edge and held there.
REQ-018 In set mode, an incMin increment SHALL advance minutes mod 60 with no carry into hours.
REQ-019 In set mode, an incHour increment SHALL advance hours mod 24, leaving minutes unchanged.
REQ-020 incHour and incMin increments on the same edge SHALL both apply.
REQ-021 Each button SHALL have its own FSM: IDLE -> HELD on a 0->1 input transition, which issues one increment on that edge.
REQ-022 HELD -> REPEAT once the button has been held REPEAT_DELAY cycles after the first increment, issuing one increment on entry.
REQ-023 REPEAT SHALL issue one increment every REPEAT_RATE cycles while the button is held.
REQ-024 Any state -> IDLE when the button reads 0; the hold counter SHALL clear.
REQ-025 Button FSMs SHALL run in both modes but SHALL issue increments only in set mode.
REQ-026 A button already held when setMode rises SHALL NOT increment until it is released and pressed again.
REQ-027 When setMode falls, counting SHALL resume from the held hh:mm:00 on the next tick.
REQ-028 If tick and a setMode change coincide, the new mode's behaviour SHALL apply on that edge.
REQ-029 minTick SHALL pulse for exactly one cycle, aligned with the digit update, for both run-mode carries and set-mode increments.
REQ-030 minTick SHALL NOT pulse on a second-only change.

Reset
REQ-031 While rst_n is 0, all time digits SHALL read 0 (00:00:00) asynchronously.
REQ-032 While rst_n is 0, minTick SHALL read 0 and both button FSMs SHALL be in IDLE with hold counters at 0.
REQ-033 Reset asserted mid-increment or mid-carry SHALL abort the operation with no partial update.
REQ-034 The first rising edge after rst_n releases SHALL behave as a normal cycle.

Verification
REQ-035 Set 23:59, leave set mode, apply 60 ticks -> 23:59:59 after 59 ticks, then 00:00:00 with a single minTick pulse.
REQ-036 Set mode at 05:59, one incMin press -> 05:00, curHour unchanged, minTick pulses once.
REQ-037 Set mode at 00:00, incHour held 20 cycles (defaults) -> increments on edges 1, 9, 13, 17; final hour 04.
REQ-038 Set mode at 23:59, incHour and incMin rise on the same edge -> 00:00 on that edge.
REQ-039 Set mode, 5 ticks applied -> seconds stay 00, no minTick pulse.
REQ-040 Run at 12:34:56, pulse rst_n low between edges -> outputs read 00:00:00 before the next edge; after release, a tick gives 00:00:01.
